// File: rtl/fetch_pair_stage_if.sv
// Fetch-side bus of the IF stage: instruction-memory port plus the registered IF/ID pair.
interface fetch_pair_stage_if #(
  parameter int unsigned PC_W = 32
);
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [15:0]     if_id_instr1;
  logic [15:0]     if_id_instr2;
  logic [PC_W-1:0] if_id_pc;
  logic            if_id_valid;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output if_id_instr1,
    output if_id_instr2,
    output if_id_pc,
    output if_id_valid
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  if_id_instr1,
    input  if_id_instr2,
    input  if_id_pc,
    input  if_id_valid
  );
endinterface

// File: rtl/fetch_pair_stage.sv
// IF stage + IF/ID register for a 2x16-bit fetch word; fetched word lands in IF/ID one edge later.
// stall holds PC and IF/ID; exception > jump/branch redirects flush IF/ID and override stall.
module fetch_pair_stage #(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(32'h0000_0100)
) (
  input  logic               clk,
  input  logic               reset,
  fetch_pair_stage_if.master bus,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic               jump,
  input  logic [PC_W-1:0]    target,
  input  logic               invalid,
  input  logic               cause_in,
  output logic [PC_W-1:0]    epc,
  output logic               cause,
  output logic               exc_taken
);

  typedef struct packed {
    logic [15:0] alu_slot;
    logic [15:0] mem_slot;
  } fetch_word_t;

  typedef struct packed {
    logic [15:0]     instr1;
    logic [15:0]     instr2;
    logic [PC_W-1:0] pc;
    logic            valid;
  } pair_t;

  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  fetch_word_t     word;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_nxt;
  pair_t           pair_q;
  pair_t           pair_nxt;
  logic [PC_W-1:0] epc_nxt;
  logic            cause_nxt;
  logic            exc_nxt;
  logic            exc_fire;
  logic            redirect;

  assign word     = bus.imem_rdata;
  // A fault is only meaningful for a live pair; bubbles never raise exceptions.
  assign exc_fire = invalid && pair_q.valid;
  assign redirect = jump || branch_taken;

  always_comb begin
    pc_nxt    = pc_q;
    pair_nxt  = pair_q;
    epc_nxt   = epc;
    cause_nxt = cause;
    exc_nxt   = 1'b0;
    if (exc_fire) begin
      pc_nxt          = EXC_VECTOR;
      pair_nxt.instr1 = '0;
      pair_nxt.instr2 = '0;
      pair_nxt.valid  = 1'b0;
      epc_nxt         = pair_q.pc;
      cause_nxt       = cause_in;
      exc_nxt         = 1'b1;
    end else if (redirect) begin
      pc_nxt          = target & ALIGN_MASK;
      pair_nxt.instr1 = '0;
      pair_nxt.instr2 = '0;
      pair_nxt.valid  = 1'b0;
    end else if (!stall) begin
      pc_nxt          = pc_q + PC_STEP;
      pair_nxt.instr1 = word.alu_slot;
      pair_nxt.instr2 = word.mem_slot;
      pair_nxt.pc     = pc_q;
      pair_nxt.valid  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      pair_q    <= '0;
      epc       <= '0;
      cause     <= 1'b0;
      exc_taken <= 1'b0;
    end else begin
      pc_q      <= pc_nxt;
      pair_q    <= pair_nxt;
      epc       <= epc_nxt;
      cause     <= cause_nxt;
      exc_taken <= exc_nxt;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.if_id_instr1 = pair_q.instr1;
  assign bus.if_id_instr2 = pair_q.instr2;
  assign bus.if_id_pc     = pair_q.pc;
  assign bus.if_id_valid  = pair_q.valid;

endmodule

// File: tb/tb_fetch_pair_stage.sv
// Scoreboard bench: directed vectors push hand-computed post-edge state; a negedge monitor pops and compares.
module tb_fetch_pair_stage;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default 32-bit configuration
  logic        rst_a, stall_a, br_a, jmp_a, inv_a, cin_a;
  logic [31:0] tgt_a, epc_a;
  logic        cause_a, exc_a;
  fetch_pair_stage_if #(.PC_W(32)) bus_a ();

  fetch_pair_stage dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a),
    .stall(stall_a), .branch_taken(br_a), .jump(jmp_a), .target(tgt_a),
    .invalid(inv_a), .cause_in(cin_a),
    .epc(epc_a), .cause(cause_a), .exc_taken(exc_a)
  );

  // DUT B: narrow PC to exercise wrap-around
  logic        rst_b, stall_b, br_b, jmp_b, inv_b, cin_b;
  logic [7:0]  tgt_b, epc_b;
  logic        cause_b, exc_b;
  fetch_pair_stage_if #(.PC_W(8)) bus_b ();

  fetch_pair_stage #(.PC_W(8), .RESET_PC(8'h10), .EXC_VECTOR(8'h80)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b),
    .stall(stall_b), .branch_taken(br_b), .jump(jmp_b), .target(tgt_b),
    .invalid(inv_b), .cause_in(cin_b),
    .epc(epc_b), .cause(cause_b), .exc_taken(exc_b)
  );

  typedef struct {
    int          id;
    int          due;
    logic        sel;
    logic [31:0] pc;
    logic [15:0] i1;
    logic [15:0] i2;
    logic [31:0] ipc;
    logic        v;
    logic [31:0] epc;
    logic        c;
    logic        x;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   vec_id   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL v%0d %s: got %h expected %h", id, nm, act, req);
    end
  endtask

  // sel=0 drives DUT A (B held in reset), sel=1 drives DUT B (A held in reset).
  task automatic apply(
    input logic sel, input logic rst, input logic stl, input logic br, input logic jmp,
    input logic inv, input logic cin, input logic [31:0] tgt, input logic [31:0] rdata,
    input logic [31:0] e_pc, input logic [15:0] e_i1, input logic [15:0] e_i2,
    input logic [31:0] e_ipc, input logic e_v, input logic [31:0] e_epc,
    input logic e_c, input logic e_x);
    exp_t e;
    @(posedge clk);
    #1;
    if (!sel) begin
      rst_a = rst; stall_a = stl; br_a = br; jmp_a = jmp; inv_a = inv; cin_a = cin;
      tgt_a = tgt; bus_a.imem_rdata = rdata;
      rst_b = 1'b1; stall_b = 1'b0; br_b = 1'b0; jmp_b = 1'b0; inv_b = 1'b0; cin_b = 1'b0;
    end else begin
      rst_b = rst; stall_b = stl; br_b = br; jmp_b = jmp; inv_b = inv; cin_b = cin;
      tgt_b = tgt[7:0]; bus_b.imem_rdata = rdata;
      rst_a = 1'b1; stall_a = 1'b0; br_a = 1'b0; jmp_a = 1'b0; inv_a = 1'b0; cin_a = 1'b0;
    end
    e.id = vec_id; e.due = edge_cnt + 1; e.sel = sel;
    e.pc = e_pc; e.i1 = e_i1; e.i2 = e_i2; e.ipc = e_ipc; e.v = e_v;
    e.epc = e_epc; e.c = e_c; e.x = e_x;
    q.push_back(e);
    vec_id++;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] a_pc, a_ipc, a_epc;
    logic [15:0] a_i1, a_i2;
    logic        a_v, a_c, a_x;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= edge_cnt) begin
        e = q.pop_front();
        chk(e.id, "due_edge", edge_cnt, e.due);
        if (!e.sel) begin
          a_pc = bus_a.imem_addr; a_i1 = bus_a.if_id_instr1; a_i2 = bus_a.if_id_instr2;
          a_ipc = bus_a.if_id_pc; a_v = bus_a.if_id_valid;
          a_epc = epc_a; a_c = cause_a; a_x = exc_a;
        end else begin
          a_pc = {24'h0, bus_b.imem_addr}; a_i1 = bus_b.if_id_instr1; a_i2 = bus_b.if_id_instr2;
          a_ipc = {24'h0, bus_b.if_id_pc}; a_v = bus_b.if_id_valid;
          a_epc = {24'h0, epc_b}; a_c = cause_b; a_x = exc_b;
        end
        chk(e.id, "imem_addr", a_pc, e.pc);
        chk(e.id, "instr1", {16'h0, a_i1}, {16'h0, e.i1});
        chk(e.id, "instr2", {16'h0, a_i2}, {16'h0, e.i2});
        chk(e.id, "if_id_pc", a_ipc, e.ipc);
        chk(e.id, "valid", {31'h0, a_v}, {31'h0, e.v});
        chk(e.id, "epc", a_epc, e.epc);
        chk(e.id, "cause", {31'h0, a_c}, {31'h0, e.c});
        chk(e.id, "exc_taken", {31'h0, a_x}, {31'h0, e.x});
      end
    end
  end

  initial begin : stimulus
    rst_a = 1'b1; stall_a = 1'b0; br_a = 1'b0; jmp_a = 1'b0; inv_a = 1'b0; cin_a = 1'b0;
    tgt_a = '0; bus_a.imem_rdata = '0;
    rst_b = 1'b1; stall_b = 1'b0; br_b = 1'b0; jmp_b = 1'b0; inv_b = 1'b0; cin_b = 1'b0;
    tgt_b = '0; bus_b.imem_rdata = '0;
    repeat (2) @(posedge clk);

    //    sel rst stl br jmp inv cin target        rdata          pc            i1        i2        if_id_pc     v  epc          c  x
    apply(0, 1,  0,  0, 0,  0,  0,  32'h0,        32'h0,        32'h0,        16'h0,    16'h0,    32'h0,       0, 32'h0,       0, 0);
    apply(0, 0,  0,  0, 0,  0,  0,  32'h0,        32'h1234ABCD, 32'h4,        16'h1234, 16'hABCD, 32'h0,       1, 32'h0,       0, 0);
    apply(0, 0,  0,  0, 0,  0,  0,  32'h0,        32'h00000000, 32'h8,        16'h0,    16'h0,    32'h4,       1, 32'h0,       0, 0);
    // three stalled edges at pc=8
    apply(0, 0,  1,  0, 0,  0,  0,  32'h0,        32'hAAAA5555, 32'h8,        16'h0,    16'h0,    32'h4,       1, 32'h0,       0, 0);
    apply(0, 0,  1,  0, 0,  0,  0,  32'h0,        32'hAAAA5555, 32'h8,        16'h0,    16'h0,    32'h4,       1, 32'h0,       0, 0);
    apply(0, 0,  1,  0, 0,  0,  0,  32'h0,        32'hAAAA5555, 32'h8,        16'h0,    16'h0,    32'h4,       1, 32'h0,       0, 0);
    apply(0, 0,  0,  0, 0,  0,  0,  32'h0,        32'hAAAA5555, 32'hC,        16'hAAAA, 16'h5555, 32'h8,       1, 32'h0,       0, 0);
    apply(0, 0,  0,  0, 0,  0,  0,  32'h0,        32'h0BADF00D, 32'h10,       16'h0BAD, 16'hF00D, 32'hC,       1, 32'h0,       0, 0);
    // jump to unaligned 0x43 -> 0x40, then bubble fills
    apply(0, 0,  0,  0, 1,  0,  0,  32'h43,       32'hDEADBEEF, 32'h40,       16'h0,    16'h0,    32'hC,       0, 32'h0,       0, 0);
    apply(0, 0,  0,  0, 0,  0,  0,  32'h0,        32'h11112222, 32'h44,       16'h1111, 16'h2222, 32'h40,      1, 32'h0,       0, 0);
    apply(0, 0,  0,  0, 1,  0,  0,  32'h24,       32'h33334444, 32'h24,       16'h0,    16'h0,    32'h40,      0, 32'h0,       0, 0);
    // invalid on a bubble is ignored
    apply(0, 0,  0,  0, 0,  1,  1,  32'h0,        32'h55556666, 32'h28,       16'h5555, 16'h6666, 32'h24,      1, 32'h0,       0, 0);
    // exception beats stall and branch
    apply(0, 0,  1,  1, 0,  1,  0,  32'h80,       32'h77778888, 32'h100,      16'h0,    16'h0,    32'h24,      0, 32'h24,      0, 1);
    apply(0, 0,  0,  0, 0,  0,  0,  32'h0,        32'h9999AAAA, 32'h104,      16'h9999, 16'hAAAA, 32'h100,     1, 32'h24,      0, 0);
    apply(0, 0,  0,  0, 0,  1,  1,  32'h0,        32'h00000000, 32'h100,      16'h0,    16'h0,    32'h100,     0, 32'h100,     1, 1);
    // jump+branch together, invalid on bubble ignored
    apply(0, 0,  0,  1, 1,  1,  0,  32'h203,      32'h00000000, 32'h200,      16'h0,    16'h0,    32'h100,     0, 32'h100,     1, 0);
    apply(0, 0,  1,  1, 0,  0,  0,  32'h31,       32'hCAFE0001, 32'h30,       16'h0,    16'h0,    32'h100,     0, 32'h100,     1, 0);
    apply(0, 0,  0,  0, 0,  0,  0,  32'h0,        32'hFEED0002, 32'h34,       16'hFEED, 16'h0002, 32'h30,      1, 32'h100,     1, 0);
    // reset wins over jump/stall/invalid
    apply(0, 1,  1,  0, 1,  1,  0,  32'h500,      32'h00000000, 32'h0,        16'h0,    16'h0,    32'h0,       0, 32'h0,       0, 0);
    apply(0, 0,  0,  0, 0,  0,  0,  32'h0,        32'h13572468, 32'h4,        16'h1357, 16'h2468, 32'h0,       1, 32'h0,       0, 0);

    // PC_W=8, RESET_PC=0x10, EXC_VECTOR=0x80
    apply(1, 1,  0,  0, 0,  0,  0,  32'h0,        32'h0,        32'h10,       16'h0,    16'h0,    32'h0,       0, 32'h0,       0, 0);
    apply(1, 0,  0,  0, 0,  0,  0,  32'h0,        32'h01020304, 32'h14,       16'h0102, 16'h0304, 32'h10,      1, 32'h0,       0, 0);
    apply(1, 0,  0,  0, 1,  0,  0,  32'hFE,       32'h0,        32'hFC,       16'h0,    16'h0,    32'h10,      0, 32'h0,       0, 0);
    apply(1, 0,  0,  0, 0,  0,  0,  32'h0,        32'h0A0B0C0D, 32'h00,       16'h0A0B, 16'h0C0D, 32'hFC,      1, 32'h0,       0, 0);
    apply(1, 0,  0,  0, 0,  1,  1,  32'h0,        32'h0,        32'h80,       16'h0,    16'h0,    32'hFC,      0, 32'hFC,      1, 1);
    apply(1, 1,  0,  0, 1,  0,  0,  32'h40,       32'h0,        32'h10,       16'h0,    16'h0,    32'h0,       0, 32'h0,       0, 0);
    apply(1, 0,  0,  0, 0,  0,  0,  32'h0,        32'h11112222, 32'h14,       16'h1111, 16'h2222, 32'h10,      1, 32'h0,       0, 0);

    repeat (4) @(posedge clk);
    chk(-1, "scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
